// File: rtl/flp_pkg.sv
// Shared constants for the flp_* floating-point blocks (FP32 layout).
package flp_pkg;

    // Exponent, stored-significand and rounding-bit widths.
    localparam int EWIDTH  = 8;
    localparam int SWIDTH  = 23;
    localparam int RSWIDTH = 2;

    // Unrounded significand in, rounded significand out, exponent adjust.
    localparam int IW = SWIDTH + 1 + RSWIDTH;
    localparam int OW = SWIDTH + 1;
    localparam int XW = EWIDTH + 2;

    // Width of a requester index; at least one bit so ports stay legal.
    function automatic int flp_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flp_round_arb_if.sv
// Requester-side and consumer-side handshake bundle of the shared rounder.
interface flp_round_arb_if
    import flp_pkg::*;
#(
    parameter int NREQ = 4
);
    localparam int IDW = flp_idw(NREQ);

    logic [NREQ-1:0]    i_vld;
    logic [NREQ-1:0]    o_rdy;
    logic [NREQ*IW-1:0] i_sg;
    logic               o_vld;
    logic               i_rdy;
    logic [OW-1:0]      o_sg;
    logic [XW-1:0]      o_exd;
    logic [IDW-1:0]     o_id;

    // Drives requests and consumes results.
    modport master (
        output i_vld, i_sg, i_rdy,
        input  o_rdy, o_vld, o_sg, o_exd, o_id
    );

    // The arbiter itself.
    modport slave (
        input  i_vld, i_sg, i_rdy,
        output o_rdy, o_vld, o_sg, o_exd, o_id
    );

endinterface

// File: rtl/flp_round.sv
// Round-to-nearest-even of an unrounded significand carrying RSWIDTH extra
// bits (guard + sticky). A carry out of the top bit renormalises the result
// by one place and reports +1 on the exponent adjustment. Needs RSWIDTH >= 2.
module flp_round #(
    parameter int EWIDTH  = 8,
    parameter int SWIDTH  = 23,
    parameter int RSWIDTH = 2,
    localparam int IW = SWIDTH + 1 + RSWIDTH,
    localparam int OW = SWIDTH + 1,
    localparam int XW = EWIDTH + 2
) (
    input  logic [IW-1:0] sg_in,
    output logic [OW-1:0] sg_out,
    output logic [XW-1:0] exd
);

    logic          guard;
    logic          sticky;
    logic          lsb;
    logic          round_up;
    logic [OW:0]   sum;

    assign guard    = sg_in[RSWIDTH-1];
    assign sticky   = |sg_in[RSWIDTH-2:0];
    assign lsb      = sg_in[RSWIDTH];
    assign round_up = guard & (sticky | lsb);
    assign sum      = {1'b0, sg_in[IW-1:RSWIDTH]} + {{OW{1'b0}}, round_up};

    // Carry out means the significand became 1.000..0 one binade higher.
    assign sg_out = sum[OW] ? sum[OW:1] : sum[OW-1:0];
    assign exd    = XW'(sum[OW]);

endmodule

// File: rtl/flp_rr_pick.sv
// Round-robin pick: first asserted request at or above ptr, wrapping at NREQ.
module flp_rr_pick
    import flp_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IDW = flp_idw(NREQ)
) (
    input  logic [IDW-1:0]  ptr,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    // Rotating priority search starting at ptr.
    always_comb begin
        int k;
        // NOTE: every output gets a default before the search so no path
        // leaves it unassigned, which would otherwise infer a latch.
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = 0;
        for (int i = 0; i < NREQ; i++) begin
            k = (int'(ptr) + i) % NREQ;
            if (!any && req[k]) begin
                any    = 1'b1;
                gnt[k] = 1'b1;
                idx    = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/flp_round_arb.sv
// Shares one flp_round between NREQ requesters. A round-robin grant selects
// one offered significand per cycle; the rounded result sits in a one-entry
// output register that can drain and refill in the same cycle.
module flp_round_arb
    import flp_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic          clk,
    input  logic          rst,
    flp_round_arb_if.slave bus
);

    localparam int IDW = flp_idw(NREQ);

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  idx;
    logic            any;
    logic            slot_free;
    logic            take;
    logic [IW-1:0]   sel_sg;
    logic [OW-1:0]   rnd_sg;
    logic [XW-1:0]   rnd_exd;

    logic            vld_q;
    logic [OW-1:0]   sg_q;
    logic [XW-1:0]   exd_q;
    logic [IDW-1:0]  id_q;

    flp_rr_pick #(.NREQ(NREQ)) u_pick (
        .ptr (ptr),
        .req (bus.i_vld),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

    // The slot accepts a new result when empty or when its content leaves now.
    assign slot_free = !vld_q || bus.i_rdy;
    assign take      = any && slot_free && !rst;
    assign bus.o_rdy = take ? gnt : '0;

    assign sel_sg = bus.i_sg[idx*IW +: IW];

    flp_round #(
        .EWIDTH  (EWIDTH),
        .SWIDTH  (SWIDTH),
        .RSWIDTH (RSWIDTH)
    ) u_round (
        .sg_in  (sel_sg),
        .sg_out (rnd_sg),
        .exd    (rnd_exd)
    );

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            vld_q <= 1'b0;
            sg_q  <= '0;
            exd_q <= '0;
            id_q  <= '0;
            ptr   <= '0;
        end else if (take) begin
            vld_q <= 1'b1;
            sg_q  <= rnd_sg;
            exd_q <= rnd_exd;
            id_q  <= idx;
            ptr   <= (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
        end else if (vld_q && bus.i_rdy) begin
            vld_q <= 1'b0;
        end
    end

    assign bus.o_vld = vld_q;
    assign bus.o_sg  = sg_q;
    assign bus.o_exd = exd_q;
    assign bus.o_id  = id_q;

endmodule

// File: tb/tb_flp_round_arb.sv
// Scoreboard bench for flp_round_arb: a driver issues stimulus and queues the
// expected result of every accepted request; a monitor checks each presented
// result against the queue head and pops it when the consumer takes it.
module tb_flp_round_arb;
    import flp_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = flp_idw(NREQ);

    typedef struct packed {
        logic [OW-1:0]  sg;
        logic [XW-1:0]  exd;
        logic [IDW-1:0] id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    flp_round_arb_if #(.NREQ(NREQ)) bus ();

    flp_round_arb #(.NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pointer, slot occupancy, pending results.
    int            m_ptr = 0;
    logic          m_vld = 1'b0;
    exp_t          exp_q[$];
    int            obs_ids[$];
    logic [NREQ-1:0] last_rdy;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Nearest-even rounding of x / 2^RSWIDTH, renormalised on overflow.
    function automatic exp_t ref_round(input logic [IW-1:0] x, input int id);
        exp_t r;
        longint unsigned q, rem, half;
        int e;
        q    = longint'(x) >> RSWIDTH;
        rem  = longint'(x) % (64'd1 << RSWIDTH);
        half = 64'd1 << (RSWIDTH - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        e = 0;
        if (q >= (64'd1 << OW)) begin
            q = q / 2;
            e = 1;
        end
        r.sg  = OW'(q);
        r.exd = XW'(e);
        r.id  = IDW'(id);
        return r;
    endfunction

    // First requester at or after p, wrapping; -1 when nobody asks.
    function automatic int ref_pick(input int p, input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++)
            if (v[(p + i) % NREQ]) return (p + i) % NREQ;
        return -1;
    endfunction

    // One clock of stimulus; updates the model at the edge.
    task automatic drive(input logic r, input logic [NREQ-1:0] v,
                         input logic [NREQ*IW-1:0] s, input logic rd);
        int g;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        rst       = r;
        bus.i_vld = v;
        bus.i_sg  = s;
        bus.i_rdy = rd;
        #1;
        exp_rdy = '0;
        g = -1;
        if (!r && (!m_vld || rd)) begin
            g = ref_pick(m_ptr, v);
            if (g >= 0) begin
                exp_rdy[g] = 1'b1;
                exp_q.push_back(ref_round(s[g*IW +: IW], g));
            end
        end
        last_rdy = bus.o_rdy;
        check("o_rdy", 64'(bus.o_rdy), 64'(exp_rdy));
        @(posedge clk);
        if (r) begin
            m_vld = 1'b0;
            m_ptr = 0;
            exp_q.delete();
        end else if (g >= 0) begin
            m_vld = 1'b1;
            m_ptr = (g + 1) % NREQ;
        end else if (m_vld && rd) begin
            m_vld = 1'b0;
        end
        #1;
    endtask

    // Monitor: compare the presented result, pop on output transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                check("o_vld", 64'(bus.o_vld), 64'(m_vld));
                if (bus.o_vld) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_result: got id %0d, expected no result", bus.o_id);
                    end else begin
                        e = exp_q[0];
                        check("o_sg",  64'(bus.o_sg),  64'(e.sg));
                        check("o_exd", 64'(bus.o_exd), 64'(e.exd));
                        check("o_id",  64'(bus.o_id),  64'(e.id));
                        if (bus.i_rdy) begin
                            void'(exp_q.pop_front());
                            obs_ids.push_back(int'(bus.o_id));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ*IW-1:0] s;
        logic [NREQ-1:0]    v;
        logic [IW-1:0]      x;
        int                 want_ids[5];

        bus.i_vld = '0;
        bus.i_sg  = '0;
        bus.i_rdy = 1'b0;
        for (int k = 0; k < NREQ; k++) s[k*IW +: IW] = IW'(k * 37 + 5);

        // Reset held two cycles with every requester asking.
        drive(1'b1, '1, s, 1'b1);
        drive(1'b1, '1, s, 1'b1);
        check("rst_o_vld", 64'(bus.o_vld), 64'd0);
        check("rst_o_sg",  64'(bus.o_sg),  64'd0);
        check("rst_o_exd", 64'(bus.o_exd), 64'd0);
        check("rst_o_id",  64'(bus.o_id),  64'd0);

        // Round-robin with all requesting: ids 0,1,2,3,0.
        obs_ids.delete();
        drive(1'b0, '1, s, 1'b1);
        check("first_grant", 64'(last_rdy), 64'b0001);
        for (int i = 0; i < 4; i++) drive(1'b0, '1, s, 1'b1);
        drive(1'b0, '0, s, 1'b1);
        want_ids = '{0, 1, 2, 3, 0};
        check("rr_count", 64'(obs_ids.size()), 64'd5);
        for (int i = 0; i < 5 && i < obs_ids.size(); i++)
            check("rr_id", 64'(obs_ids[i]), 64'(want_ids[i]));

        // Single request from requester 2.
        s[2*IW +: IW] = 26'h000_0004;
        drive(1'b0, 4'b0100, s, 1'b1);
        check("single_vld", 64'(bus.o_vld), 64'd1);
        check("single_sg",  64'(bus.o_sg),  64'h00_0001);
        check("single_exd", 64'(bus.o_exd), 64'd0);
        check("single_id",  64'(bus.o_id),  64'd2);

        // Rounding overflow from requester 1 (drain+refill cycle).
        s[1*IW +: IW] = 26'h3ff_ffff;
        drive(1'b0, 4'b0010, s, 1'b1);
        check("ovf_sg",      64'(bus.o_sg),          64'h80_0000);
        check("ovf_exd_nz",  64'(bus.o_exd != '0),   64'd1);
        check("ovf_id",      64'(bus.o_id),          64'd1);

        // Stall five cycles, then release: new grant completes without a bubble.
        for (int i = 0; i < 5; i++) drive(1'b0, '1, s, 1'b0);
        drive(1'b0, '1, s, 1'b1);
        check("stall_refill_vld", 64'(bus.o_vld), 64'd1);
        check("stall_refill_id",  64'(bus.o_id),  64'd2);

        // Reset pulse while a result is stalled.
        drive(1'b0, '0, s, 1'b0);
        drive(1'b1, '1, s, 1'b0);
        check("midrst_o_vld", 64'(bus.o_vld), 64'd0);
        drive(1'b0, '1, s, 1'b1);
        check("midrst_grant", 64'(last_rdy), 64'b0001);

        // Randomised traffic.
        for (int c = 0; c < 400; c++) begin
            v = NREQ'($urandom);
            for (int k = 0; k < NREQ; k++) begin
                x = IW'($urandom);
                if ($urandom_range(7) == 0) x = '1;
                if ($urandom_range(7) == 0) x[RSWIDTH-1:0] = 2'b10;
                s[k*IW +: IW] = x;
            end
            drive($urandom_range(59) == 0, v, s, $urandom_range(9) < 7);
        end

        // Drain and confirm nothing is left pending.
        for (int i = 0; i < 3; i++) drive(1'b0, '0, s, 1'b1);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
